// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode map and control FSM states.
// Opcodes 0000-1000 keep the encoding of the original combinational ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'b0000,
    OpSub = 4'b0001,
    OpAnd = 4'b0010,
    OpOr  = 4'b0011,
    OpXor = 4'b0100,
    OpNot = 4'b0101,
    OpShl = 4'b0110,
    OpShr = 4'b0111,
    OpCmp = 4'b1000,
    OpAdc = 4'b1001,
    OpSbc = 4'b1010,
    OpRol = 4'b1011,
    OpRor = 4'b1100,
    OpAsr = 4'b1101,
    OpMul = 4'b1110,
    OpIll = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
//  in_valid/in_ready + alu_op/operand_a/operand_b : request channel
//  out_valid/out_ready + alu_result + flags       : registered response channel
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic             negative_flag;
  logic             illegal_op;

  modport master (
    output in_valid, alu_op, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, alu_result, zero_flag, carry_flag, overflow_flag,
           negative_flag, illegal_op
  );

  modport slave (
    input  in_valid, alu_op, operand_a, operand_b, out_ready,
    output in_ready, out_valid, alu_result, zero_flag, carry_flag, overflow_flag,
           negative_flag, illegal_op
  );

endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
//  clk, rst : clock and synchronous active-high reset (aborts a running multiply)
//  start    : load a/b and begin
//  a, b     : WIDTH-bit unsigned operands, sampled on start
//  done     : product is final (held until the cycle after it is seen)
//  product  : 2*WIDTH-bit running/final product
module alu_seq_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      // The first partial product is folded into the load so the whole multiply
      // takes WIDTH clocks including the start edge.
      acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_q  <= {{(WIDTH - 1){1'b0}}, a, 1'b0};
      mplier_q <= b >> 1;
      cnt_q    <= CntW'(WIDTH - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CntW'(1);
      end
    end
  end

  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with stored carry for multi-word arithmetic.
//  clk, rst : clock and synchronous active-high reset
//  bus      : alu_seq_if slave port (request, response, result and flags)
// Single-cycle ops are evaluated on the accept edge and land in the output
// registers directly; MUL hands its operands to the iterative multiplier.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  state_e state_q, state_d;
  logic   load_out, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_op_e          op;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic [WIDTH:0]   sum, diff;
  logic             add_ovf, sub_ovf;

  logic [WIDTH-1:0] result_d, result_q;
  logic zero_d, zero_q, cflag_d, cflag_q, ovf_d, ovf_q, neg_d, neg_q, ill_d, ill_q;
  logic carry_q;

  assign op = alu_op_e'(bus.alu_op);
  assign a  = bus.operand_a;
  assign b  = bus.operand_b;

  // Stored carry only feeds the carry-chained forms.
  assign cin  = ((op == OpAdc) || (op == OpSbc)) && carry_q;
  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  alu_seq_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    result_d = '0;
    cflag_d  = 1'b0;
    ovf_d    = 1'b0;
    ill_d    = 1'b0;
    case (op)
      OpAdd, OpAdc: begin
        result_d = sum[WIDTH-1:0];
        cflag_d  = sum[WIDTH];
        ovf_d    = add_ovf;
      end
      OpSub, OpSbc: begin
        result_d = diff[WIDTH-1:0];
        cflag_d  = diff[WIDTH];
        ovf_d    = sub_ovf;
      end
      OpAnd: result_d = a & b;
      OpOr:  result_d = a | b;
      OpXor: result_d = a ^ b;
      OpNot: result_d = ~a;
      OpShl: begin
        result_d = {a[WIDTH-2:0], 1'b0};
        cflag_d  = a[WIDTH-1];
      end
      OpShr: begin
        result_d = {1'b0, a[WIDTH-1:1]};
        cflag_d  = a[0];
      end
      OpCmp: begin
        result_d = a;
        cflag_d  = diff[WIDTH];
        ovf_d    = sub_ovf;
      end
      OpRol: begin
        result_d = {a[WIDTH-2:0], carry_q};
        cflag_d  = a[WIDTH-1];
      end
      OpRor: begin
        result_d = {carry_q, a[WIDTH-1:1]};
        cflag_d  = a[0];
      end
      OpAsr: begin
        result_d = {a[WIDTH-1], a[WIDTH-1:1]};
        cflag_d  = a[0];
      end
      OpIll: ill_d = 1'b1;
      default: result_d = '0;
    endcase

    // In BUSY the request bus is not ours any more; the multiplier owns the result.
    if (state_q == StBusy) begin
      result_d = mul_product[WIDTH-1:0];
      cflag_d  = |mul_product[2*WIDTH-1:WIDTH];
      ovf_d    = 1'b0;
      ill_d    = 1'b0;
    end

    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
    if ((state_q != StBusy) && (op == OpCmp)) begin
      zero_d = (diff[WIDTH-1:0] == '0);
      neg_d  = diff[WIDTH-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (op == OpMul) begin
            mul_start = 1'b1;
            state_d   = StBusy;
          end else begin
            load_out = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StBusy: begin
        if (mul_done) begin
          load_out = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      cflag_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      ill_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else if (load_out) begin
      result_q <= result_d;
      zero_q   <= zero_d;
      cflag_q  <= cflag_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      ill_q    <= ill_d;
      // An illegal op must not disturb a multi-word chain in progress.
      if (!ill_d) carry_q <= cflag_d;
    end
  end

  assign bus.in_ready      = (state_q == StIdle);
  assign bus.out_valid     = (state_q == StDone);
  assign bus.alu_result    = result_q;
  assign bus.zero_flag     = zero_q;
  assign bus.carry_flag    = cflag_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.negative_flag = neg_q;
  assign bus.illegal_op    = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int OpAdd = 0, OpSub = 1, OpAnd = 2, OpOr = 3, OpXor = 4, OpNot = 5, OpShl = 6;
  localparam int OpShr = 7, OpCmp = 8, OpAdc = 9, OpSbc = 10, OpRol = 11, OpRor = 12;
  localparam int OpAsr = 13, OpMul = 14, OpIll = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] o_res;
  logic [4:0] o_flags;  // {z, c, v, n, ill}
  int         o_lat, o_stray;
  bit         o_to;

  // Reference model: plain integer arithmetic over the opcode definitions.
  function automatic void model(input int w, input int op, input longint a, input longint b,
                                input bit cq, output longint r, output logic [4:0] flags);
    longint m, half, sa, sb, t, ts, cin;
    bit z, c, v, n, ill;
    m = longint'(1) << w;
    half = m / 2;
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    cin = ((op == OpAdc) || (op == OpSbc)) ? longint'(cq) : 0;
    r = 0; c = 0; v = 0; ill = 0; t = 0;
    case (op)
      OpAdd, OpAdc: begin
        t = a + b + cin; r = t % m; c = (t >= m);
        ts = sa + sb + cin; v = (ts >= half) || (ts < -half);
      end
      OpSub, OpSbc, OpCmp: begin
        t = a - b - cin; r = (t + m) % m; c = (t < 0);
        ts = sa - sb - cin; v = (ts >= half) || (ts < -half);
      end
      OpAnd: r = a & b;
      OpOr:  r = a | b;
      OpXor: r = a ^ b;
      OpNot: r = (m - 1) - a;
      OpShl: begin r = (a * 2) % m; c = (a >= half); end
      OpShr: begin r = a / 2; c = ((a % 2) == 1); end
      OpRol: begin r = (a * 2) % m + longint'(cq); c = (a >= half); end
      OpRor: begin r = a / 2 + (cq ? half : 0); c = ((a % 2) == 1); end
      OpAsr: begin r = a / 2 + ((a >= half) ? half : 0); c = ((a % 2) == 1); end
      OpMul: begin t = a * b; r = t % m; c = (t >= m); end
      default: begin r = 0; ill = 1; end
    endcase
    z = (r == 0);
    n = (r >= half);
    if (op == OpCmp) begin
      z = (a == b);
      r = a;
    end
    flags = {z, c, v, n, ill};
  endfunction

  task automatic idle_drive();
    bus8.in_valid = 0;  bus8.out_ready = 0;  bus8.alu_op = 0;  bus8.operand_a = 0;
    bus8.operand_b = 0;
    bus16.in_valid = 0; bus16.out_ready = 0; bus16.alu_op = 0; bus16.operand_a = 0;
    bus16.operand_b = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Issue one op on the 8-bit DUT and capture the first valid response.
  task automatic issue8(input int op, input logic [7:0] a, input logic [7:0] b, input bit hold);
    int n;
    o_to = 0;
    o_stray = 0;
    @(negedge clk);
    bus8.in_valid = 1; bus8.alu_op = 4'(op); bus8.operand_a = a; bus8.operand_b = b;
    bus8.out_ready = 0;
    n = 0;
    while (!bus8.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus8.in_ready) o_to = 1;
    @(posedge clk); #1;
    if (!hold) bus8.in_valid = 0;
    o_lat = 1;
    while (!bus8.out_valid && o_lat < 40) begin
      if (bus8.in_ready) o_stray++;
      @(posedge clk); #1;
      o_lat++;
    end
    bus8.in_valid = 0;
    if (!bus8.out_valid) o_to = 1;
    o_res = bus8.alu_result;
    o_flags = {bus8.zero_flag, bus8.carry_flag, bus8.overflow_flag, bus8.negative_flag,
               bus8.illegal_op};
  endtask

  task automatic release8();
    bus8.out_ready = 1;
    @(posedge clk); #1;
    bus8.out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    n_vec++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", bus8.in_ready, bus8.out_valid);
      n_err++;
    end
    n_vec++;
    if (bus8.alu_result !== 8'h00) begin
      $display("FAIL reset_result: got %h want 00", bus8.alu_result); n_err++;
    end
    n_vec++;
    if ({bus8.zero_flag, bus8.carry_flag, bus8.overflow_flag, bus8.negative_flag,
         bus8.illegal_op} !== 5'b0) begin
      $display("FAIL reset_flags: got %b%b%b%b%b want 00000", bus8.zero_flag, bus8.carry_flag,
               bus8.overflow_flag, bus8.negative_flag, bus8.illegal_op);
      n_err++;
    end
    n_vec++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.alu_result !== 16'h0) begin
      $display("FAIL reset_w16: in_ready=%b out_valid=%b result=%h, want 1 0 0000",
               bus16.in_ready, bus16.out_valid, bus16.alu_result);
      n_err++;
    end
  endtask

  task automatic test_add();
    issue8(OpAdd, 8'h7F, 8'h01, 0);
    n_vec++;
    if (o_to || o_lat != 1 || o_stray != 0) begin
      $display("FAIL add_latency: got lat=%0d stray=%0d to=%0b want lat=1 stray=0 to=0",
               o_lat, o_stray, o_to);
      n_err++;
    end
    n_vec++;
    if (o_res !== 8'h80 || o_flags !== 5'b00110) begin
      $display("FAIL add_7f_01: got %h zcvni=%b want 80 00110", o_res, o_flags); n_err++;
    end
    release8();
  endtask

  task automatic test_sub_adc();
    issue8(OpSub, 8'h05, 8'h0A, 0);
    n_vec++;
    if (o_res !== 8'hFB || o_flags !== 5'b01010) begin
      $display("FAIL sub_05_0a: got %h zcvni=%b want fb 01010", o_res, o_flags); n_err++;
    end
    release8();
    issue8(OpAdc, 8'h01, 8'h01, 0);
    n_vec++;
    if (o_res !== 8'h03 || o_flags !== 5'b00000) begin
      $display("FAIL adc_carry_in: got %h zcvni=%b want 03 00000", o_res, o_flags); n_err++;
    end
    release8();
  endtask

  task automatic test_mul();
    issue8(OpMul, 8'h10, 8'h20, 1);
    n_vec++;
    if (o_to || o_lat != 9 || o_stray != 0) begin
      $display("FAIL mul_latency: got lat=%0d stray=%0d to=%0b want lat=9 stray=0 to=0",
               o_lat, o_stray, o_to);
      n_err++;
    end
    n_vec++;
    if (o_res !== 8'h00 || o_flags !== 5'b11000) begin
      $display("FAIL mul_10_20: got %h zcvni=%b want 00 11000", o_res, o_flags); n_err++;
    end
    release8();
  endtask

  task automatic test_backpressure();
    issue8(OpShr, 8'hA0, 8'h3C, 0);
    n_vec++;
    if (o_res !== 8'h50 || o_flags !== 5'b00000) begin
      $display("FAIL shr_a0: got %h zcvni=%b want 50 00000", o_res, o_flags); n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 || bus8.alu_result !== 8'h50 ||
          bus8.carry_flag !== 1'b0 || bus8.zero_flag !== 1'b0) begin
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b result=%h c=%b z=%b want 1 0 50 0 0",
                 i, bus8.out_valid, bus8.in_ready, bus8.alu_result, bus8.carry_flag,
                 bus8.zero_flag);
        n_err++;
      end
    end
    release8();
    n_vec++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      $display("FAIL hold_release: in_ready=%b out_valid=%b want 1 0", bus8.in_ready,
               bus8.out_valid);
      n_err++;
    end
  endtask

  task automatic test_illegal();
    issue8(OpAdd, 8'hFF, 8'h01, 0);
    release8();
    issue8(OpIll, 8'hAA, 8'hBB, 0);
    n_vec++;
    if (o_res !== 8'h00 || o_flags !== 5'b10001) begin
      $display("FAIL illegal: got %h zcvni=%b want 00 10001", o_res, o_flags); n_err++;
    end
    release8();
    issue8(OpRol, 8'h00, 8'h00, 0);
    n_vec++;
    if (o_res !== 8'h01 || o_flags !== 5'b00000) begin
      $display("FAIL rol_after_ill: got %h zcvni=%b want 01 00000", o_res, o_flags); n_err++;
    end
    release8();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    issue8(OpAdd, 8'hFF, 8'h01, 0);
    release8();
    @(negedge clk);
    bus8.in_valid = 1; bus8.alu_op = 4'(OpMul); bus8.operand_a = 8'hFF; bus8.operand_b = 8'hFF;
    @(posedge clk); #1;
    bus8.in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n_vec++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      $display("FAIL mul_abort: out_valid=%b in_ready=%b want 0 1", bus8.out_valid,
               bus8.in_ready);
      n_err++;
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      $display("FAIL mul_abort_ghost: got %0d valid cycles want 0", seen); n_err++;
    end
    issue8(OpRol, 8'h00, 8'h00, 0);
    n_vec++;
    if (o_res !== 8'h00 || o_flags !== 5'b10000) begin
      $display("FAIL carry_cleared: got %h zcvni=%b want 00 10000", o_res, o_flags); n_err++;
    end
    release8();
  endtask

  task automatic test_w16_ror();
    @(negedge clk);
    bus16.in_valid = 1; bus16.alu_op = 4'(OpRor); bus16.operand_a = 16'h0001;
    bus16.operand_b = 16'h1234;
    @(posedge clk); #1;
    bus16.in_valid = 0;
    n_vec++;
    if (bus16.out_valid !== 1'b1 || bus16.alu_result !== 16'h0000 || bus16.carry_flag !== 1'b1 ||
        bus16.zero_flag !== 1'b1 || bus16.negative_flag !== 1'b0) begin
      $display("FAIL w16_ror: valid=%b result=%h c=%b z=%b n=%b want 1 0000 1 1 0",
               bus16.out_valid, bus16.alu_result, bus16.carry_flag, bus16.zero_flag,
               bus16.negative_flag);
      n_err++;
    end
    bus16.out_ready = 1;
    @(posedge clk); #1;
    bus16.out_ready = 0;
  endtask

  task automatic test_random();
    bit         cq;
    longint     r;
    logic [4:0] ef;
    int         op;
    logic [7:0] a, b;
    apply_reset();
    cq = 0;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      model(8, op, longint'(a), longint'(b), cq, r, ef);
      issue8(op, a, b, bit'($urandom_range(0, 1)));
      n_vec++;
      if (o_to || o_lat != ((op == OpMul) ? 9 : 1)) begin
        $display("FAIL rand_lat[%0d] op=%0d: got %0d to=%0b want %0d", i, op, o_lat, o_to,
                 (op == OpMul) ? 9 : 1);
        n_err++;
      end
      n_vec++;
      if (o_res !== 8'(r) || o_flags !== ef) begin
        $display("FAIL rand[%0d] op=%0d a=%h b=%h cq=%0b: got %h zcvni=%b want %h %b", i, op, a,
                 b, cq, o_res, o_flags, 8'(r), ef);
        n_err++;
      end
      if (!ef[0]) cq = ef[3];
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      release8();
    end
  endtask

  initial begin
    rst = 1;
    idle_drive();
    test_reset();
    test_add();
    test_sub_adc();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_mid_mul();
    test_w16_ror();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
